// File: rtl/tis100_pkg.sv
// tis100_pkg: shared instruction layout, jump codes and fetch state encoding
package tis100_pkg;
  localparam int INSTR_W = 18;
  localparam int ADDR_W = 4;
  localparam int TYPE_W = 5;
  localparam int D_W = 2;
  localparam int S_W = 3;
  localparam int TYPE_LO = 0;
  localparam int D_LO = 5;
  localparam int S_LO = 7;
  localparam int IMM_LO = 10;
  localparam logic [0:INSTR_W-1] NOP = {5'b11111, 13'b0};
  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_ABS = 2'b01;
  localparam logic [1:0] JMP_REL = 2'b10;
  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_STALL} fetch_state_e;
endpackage

// File: rtl/tis100_fetch_unit_if.sv
// tis100_fetch_unit_if: program load, control_unit feedback and instruction presentation bus
interface tis100_fetch_unit_if import tis100_pkg::*; ();
  logic run, prog_we, hlt, ack, port_done, instr_valid, stalled;
  logic [0:ADDR_W-1] prog_addr, pc;
  logic [0:INSTR_W-1] prog_data;
  logic [0:1] jmpCond;
  logic [0:TYPE_W-1] instrType;
  logic [0:D_W-1] dType;
  logic [0:S_W-1] sType;
  logic [0:7] imm;
  modport master(output run, prog_we, prog_addr, prog_data, jmpCond, hlt, ack, port_done,
                 input instrType, dType, sType, imm, instr_valid, pc, stalled);
  modport slave(input run, prog_we, prog_addr, prog_data, jmpCond, hlt, ack, port_done,
                output instrType, dType, sType, imm, instr_valid, pc, stalled);
endinterface

// File: rtl/tis100_prog_mem.sv
// tis100_prog_mem: program store with synchronous write and asynchronous read
module tis100_prog_mem import tis100_pkg::*; #(
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [0:ADDR_W-1]  i_waddr,
  input  logic [0:INSTR_W-1] i_wdata,
  input  logic [0:ADDR_W-1]  i_raddr,
  output logic [0:INSTR_W-1] o_rdata
);
  logic [0:INSTR_W-1] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/tis100_fetch_unit.sv
// tis100_fetch_unit: program memory, PC sequencing with wrap/jump/stall and instruction register
module tis100_fetch_unit import tis100_pkg::*; #(
  parameter int PROG_DEPTH = 16,
  parameter int IMM_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  tis100_fetch_unit_if.slave  bus
);
  fetch_state_e r_state;
  logic [0:INSTR_W-1] r_ir, w_rd, w_mem_rd;
  logic [0:ADDR_W-1] r_pc, w_next, w_seq, w_abs, w_rel, w_rd_addr;
  logic [4:0] r_prog_len, w_inc, w_last;
  logic [0:IMM_W-1] w_imm;
  logic signed [9:0] w_sum;
  logic r_valid, w_block, w_load_we;

  assign w_imm = r_ir[IMM_LO +: IMM_W];
  assign w_inc = {1'b0, r_pc} + 5'd1;
  assign w_last = r_prog_len - 5'd1;
  assign w_seq = (w_inc == r_prog_len) ? 4'd0 : w_inc[3:0];
  assign w_abs = ({1'b0, w_imm[IMM_W-4 +: 4]} >= r_prog_len) ? 4'd0 : w_imm[IMM_W-4 +: 4];
  assign w_sum = $signed({6'b0, r_pc}) + $signed({{(10-IMM_W){w_imm[0]}}, w_imm});
  assign w_rel = w_sum[9] ? 4'd0 : (w_sum >= $signed({5'b0, r_prog_len})) ? w_last[3:0] : w_sum[3:0];
  assign w_next = (bus.jmpCond == JMP_ABS) ? w_abs : (bus.jmpCond == JMP_REL) ? w_rel : w_seq;
  assign w_block = (bus.hlt | bus.ack) & ~bus.port_done;
  assign w_load_we = bus.prog_we & (r_state == ST_LOAD);
  assign w_rd_addr = (r_state == ST_LOAD) ? 4'd0 : (r_state == ST_STALL) ? w_seq : w_next;
  // a write to address 0 on the edge run rises must land in the IR
  assign w_rd = (w_load_we && bus.prog_addr == 4'd0) ? bus.prog_data : w_mem_rd;

  tis100_prog_mem #(.DEPTH(PROG_DEPTH)) u_mem (
    .clk(clk), .i_we(w_load_we), .i_waddr(bus.prog_addr), .i_wdata(bus.prog_data),
    .i_raddr(w_rd_addr), .o_rdata(w_mem_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_LOAD;
      r_pc <= '0;
      r_ir <= NOP;
      r_valid <= 1'b0;
      r_prog_len <= '0;
    end else begin
      if (w_load_we && {1'b0, bus.prog_addr} >= r_prog_len) r_prog_len <= {1'b0, bus.prog_addr} + 5'd1;
      if (r_state == ST_LOAD) begin
        if (bus.run && r_prog_len != 5'd0) begin
          r_state <= ST_RUN;
          r_pc <= '0;
          r_ir <= w_rd;
          r_valid <= 1'b1;
        end
      end else if (!bus.run) begin
        r_state <= ST_LOAD;
        r_pc <= '0;
        r_ir <= NOP;
        r_valid <= 1'b0;
      end else if (r_state == ST_RUN && w_block) begin
        r_state <= ST_STALL;
      end else if (r_state == ST_RUN || bus.port_done) begin
        r_state <= ST_RUN;
        r_pc <= w_rd_addr;
        r_ir <= w_rd;
      end
    end
  end

  assign bus.instrType = r_ir[TYPE_LO +: TYPE_W];
  assign bus.dType = r_ir[D_LO +: D_W];
  assign bus.sType = r_ir[S_LO +: S_W];
  assign bus.imm = r_ir[IMM_LO +: 8];
  assign bus.pc = r_pc;
  assign bus.instr_valid = r_valid;
  assign bus.stalled = w_block & r_valid;
endmodule

// File: tb/tb_tis100_fetch_unit.sv
// tb_tis100_fetch_unit: directed checks of load, sequencing, jumps, stalls and reset
module tb_tis100_fetch_unit;
  logic clk = 1'b0;
  logic reset;
  int vectors = 0;
  int miscompares = 0;

  tis100_fetch_unit_if bus();
  tis100_fetch_unit dut(.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [17:0] w(input logic [4:0] t, input logic [1:0] d, input logic [2:0] s, input logic [7:0] i);
    return {t, d, s, i};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [17:0] d);
    bus.prog_we = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = d;
    tick();
    bus.prog_we = 1'b0;
  endtask

  task automatic rel(input logic [7:0] i, input logic [3:0] exp);
    bus.run = 1'b0;
    tick();
    wr(4'd1, w(5'd2, 2'd2, 3'd3, i));
    wr(4'd3, w(5'd4, 2'd0, 3'd5, 8'h44));
    bus.run = 1'b1;
    tick();
    tick();
    chk("rel_pre_pc", bus.pc, 1);
    bus.jmpCond = 2'b10;
    tick();
    chk("rel_pc", bus.pc, exp);
    bus.jmpCond = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[4] = '{1, 2, 0, 1};
    reset = 1'b0;
    bus.run = 1'b0; bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.jmpCond = 2'b00; bus.hlt = 1'b0; bus.ack = 1'b0; bus.port_done = 1'b0;
    #12;
    chk("rst_pc", bus.pc, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_type", bus.instrType, 5'h1F);
    chk("rst_imm", bus.imm, 0);
    chk("rst_stalled", bus.stalled, 0);
    reset = 1'b1;
    bus.run = 1'b1;
    tick();
    tick();
    chk("empty_valid", bus.instr_valid, 0);
    chk("empty_type", bus.instrType, 5'h1F);
    chk("empty_pc", bus.pc, 0);
    bus.run = 1'b0;
    wr(4'd0, w(5'd1, 2'd1, 3'd2, 8'h11));
    wr(4'd1, w(5'd2, 2'd2, 3'd3, 8'h22));
    wr(4'd2, w(5'd3, 2'd3, 3'd4, 8'h01));
    bus.run = 1'b1;
    tick();
    chk("first_pc", bus.pc, 0);
    chk("first_valid", bus.instr_valid, 1);
    chk("first_type", bus.instrType, 1);
    chk("first_dtype", bus.dType, 1);
    chk("first_stype", bus.sType, 2);
    chk("first_imm", bus.imm, 8'h11);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("seq_pc", bus.pc, seq[k]);
    end
    chk("seq_imm", bus.imm, 8'h22);
    tick();
    chk("abs_pre_pc", bus.pc, 2);
    bus.jmpCond = 2'b01;
    tick();
    chk("abs_pc", bus.pc, 1);
    chk("abs_type", bus.instrType, 2);
    bus.jmpCond = 2'b00;
    bus.run = 1'b0;
    tick();
    chk("load_pc", bus.pc, 0);
    chk("load_valid", bus.instr_valid, 0);
    chk("load_type", bus.instrType, 5'h1F);
    wr(4'd2, w(5'd3, 2'd3, 3'd4, 8'h0F));
    bus.run = 1'b1;
    tick(); tick(); tick();
    chk("abs_oob_pre_pc", bus.pc, 2);
    bus.jmpCond = 2'b01;
    tick();
    chk("abs_oob_pc", bus.pc, 0);
    bus.jmpCond = 2'b00;
    rel(8'hFB, 4'd0);
    rel(8'h7F, 4'd3);
    rel(8'h01, 4'd2);
    bus.run = 1'b0;
    tick();
    bus.prog_we = 1'b1; bus.prog_addr = 4'd0; bus.prog_data = w(5'd9, 2'd0, 3'd1, 8'h5A);
    bus.run = 1'b1;
    tick();
    bus.prog_we = 1'b0;
    chk("bypass_pc", bus.pc, 0);
    chk("bypass_valid", bus.instr_valid, 1);
    chk("bypass_type", bus.instrType, 9);
    chk("bypass_imm", bus.imm, 8'h5A);
    tick();
    chk("stall_pre_pc", bus.pc, 1);
    bus.ack = 1'b1;
    #1;
    chk("stall_comb", bus.stalled, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_pc", bus.pc, 1);
      chk("stall_flag", bus.stalled, 1);
      chk("stall_imm", bus.imm, 8'h01);
    end
    bus.port_done = 1'b1;
    #1;
    chk("done_stalled", bus.stalled, 0);
    tick();
    chk("done_pc", bus.pc, 2);
    bus.ack = 1'b0;
    bus.port_done = 1'b0;
    bus.hlt = 1'b1;
    tick();
    chk("hlt_pc", bus.pc, 2);
    chk("hlt_stalled", bus.stalled, 1);
    reset = 1'b0;
    #1;
    chk("arst_pc", bus.pc, 0);
    chk("arst_type", bus.instrType, 5'h1F);
    chk("arst_stalled", bus.stalled, 0);
    chk("arst_valid", bus.instr_valid, 0);
    bus.hlt = 1'b0;
    bus.run = 1'b0;
    #1;
    reset = 1'b1;
    tick();
    wr(4'd0, w(5'd2, 2'd1, 3'd1, 8'h77));
    bus.run = 1'b1;
    tick();
    chk("reload_pc", bus.pc, 0);
    chk("reload_type", bus.instrType, 2);
    chk("reload_valid", bus.instr_valid, 1);
    tick();
    chk("len1_wrap_pc", bus.pc, 0);
    chk("len1_wrap_imm", bus.imm, 8'h77);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
